fpu_arbiter: RTL and testbench
==============================

Name: fpu_arbiter

Overview:
- Shares one FPU add core between N_REQ requesters.
- Round-robin arbitration among requesters.
- Issues one operation at a time to the core using a start/done handshake.
- Returns each result on a shared response bus with a per-requester valid/ready handshake.
- Watchdog timer returns a timeout status if the core never asserts done.
- Sits between client datapaths and the FPU core; operands use the 32-bit format [31] sign, [30:25] exponent (bias 31), [24:0] mantissa.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, max cycles in WAIT before timeout (>=2).
- ID_W, $clog2(N_REQ), width of the requester index.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  requester i has an operation pending
- req_ready  out  N_REQ  operation of requester i accepted this cycle
- req_op_a  in  N_REQ*32  operand A, slice i = [32*i+31:32*i]
- req_op_b  in  N_REQ*32  operand B, same packing as req_op_a
- resp_valid  out  N_REQ  response for requester i is valid
- resp_ready  in  N_REQ  requester i consumes the response
- resp_data  out  32  result word
- resp_status  out  4  core status; bit3 = controller timeout
- resp_id  out  ID_W  index of the requester being answered
- fpu_start  out  1  one-cycle start pulse to the core
- fpu_op_a  out  32  operand A to the core, held stable from ISSUE through WAIT
- fpu_op_b  out  32  operand B to the core, held stable from ISSUE through WAIT
- fpu_done  in  1  core result valid (single-cycle pulse)
- fpu_result  in  32  core result
- fpu_status  in  4  core flags; core never drives bit3
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - state IDLE.
  - All outputs 0.
  - last_grant = N_REQ-1, so requester 0 has first priority.
  - Watchdog timer 0.
  - Latched operands, result and id all 0.
- Reset asserted mid-operation aborts the transaction: no response is produced and any later fpu_done is ignored.
- States:
  - IDLE:
    - grant = first i with req_valid[i], searching from last_grant+1 modulo N_REQ.
    - req_ready is combinational and one-hot at grant; it is 0 when no request is valid or when state != IDLE.
    - On handshake: latch op_a, op_b and the id; go to ISSUE.
  - ISSUE:
    - fpu_start=1 for exactly this cycle.
    - Clear the timer; go to WAIT.
    - fpu_done seen in ISSUE is ignored.
  - WAIT:
    - fpu_done=1: latch fpu_result and fpu_status (bit3 forced 0); go to RESP.
    - Otherwise, timer==TIMEOUT-1: latch data=0, status=4'b1000; go to RESP.
    - Otherwise, timer++.
    - fpu_done and timeout in the same cycle: done wins.
  - RESP:
    - resp_valid[id]=1, with resp_data, resp_status and resp_id driven from registers.
    - Stays stable until resp_ready[id]=1.
    - On that cycle: last_grant<=id; go to IDLE.
    - resp_ready on other bits is ignored.
- Latency:
  - Request accept to fpu_start: 1 cycle.
  - fpu_done to resp_valid: 1 cycle.
  - A new grant is possible in the cycle after response consumption, so each transaction takes at least 4 cycles.
- A requester dropping req_valid before its handshake is legal and is simply not granted.
- Only one operation is outstanding; no queueing.

Decomposition:
- Package fpu_pkg:
  - state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - EXP_W=6, MAN_W=25, BIAS=31.
  - STATUS_TIMEOUT_BIT=3.
  - TIMEOUT_STATUS=4'b1000.
- Sub-module rr_arbiter (combinational): inputs req vector and last_grant; outputs one-hot grant, grant index and any_req.

Test Plan:
- Single request: req0 with op_a=0x3E000000 (1.0), op_b=0x3E000000; stub core gives done 3 cycles after start with 0x40000000 (2.0), status 0 -> req_ready[0] 1 cycle, fpu_start 1 cycle later, resp_valid[0] with data 0x40000000, status 0, id 0.
- Contention: req0..req3 all held valid with resp_ready tied 1 -> grants in order 0,1,2,3,0; each fpu_start separated by >=4 cycles.
- Timeout: the core never asserts done, TIMEOUT=64 -> resp_valid exactly 64 cycles after entering WAIT, with data 0 and status 4'b1000; a later stray fpu_done is ignored.
- Done on last cycle: fpu_done in the same cycle timer==TIMEOUT-1 -> real result returned, status bit3=0.
- Back-pressure: resp_ready[id] held low 10 cycles -> resp_valid, data and id stay stable; req_ready stays 0; fpu_start does not pulse.
- Reset mid-WAIT: reset low for 2 cycles during WAIT -> all outputs 0 and busy 0; a subsequent req2 alone is granted first, with no response for the aborted operation.

Source files
------------

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared types and constants for the FPU arbiter slice.
//                Operand format is [31] sign, [30:25] exponent (bias 31),
//                [24:0] mantissa.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Operand field widths
   localparam int EXP_W = 6;
   localparam int MAN_W = 25;
   localparam int BIAS  = 31;

   // Status word layout: the core owns bits [2:0], bit 3 flags a watchdog expiry
   localparam int         STATUS_TIMEOUT_BIT = 3;
   localparam logic [3:0] TIMEOUT_STATUS     = 4'b1000;

   // Core status as returned to a requester: the timeout bit is never
   // allowed to come from the core itself.
   function automatic logic [3:0] core_status(input logic [3:0] raw);
      logic [3:0] s;
      s = raw;
      s[STATUS_TIMEOUT_BIT] = 1'b0;
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches the request
//                vector starting one position after the last grant,
//                wrapping modulo N_REQ; returns one-hot grant, its index
//                and whether any request was present.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import fpu_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  last_grant_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [ID_W-1:0]  grant_idx_o,
   output logic             any_req_o
);

   // Priority search from last_grant+1, first hit wins
   always_comb begin
      int   cand;
      logic found;
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      cand        = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = (int'(last_grant_i) + k) % N_REQ;
         for (int i = 0; i < N_REQ; i++) begin
            if (!found && (i == cand) && req_i[i]) begin
               grant_o[i]  = 1'b1;
               grant_idx_o = ID_W'(i);
               found       = 1'b1;
            end
         end
      end
      any_req_o = found;
   end

endmodule
`default_nettype wire

// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_arbiter
//  Description : Shares a single FPU add core between N_REQ requesters.
//                Round-robin grant, one operation in flight, start/done
//                handshake to the core with a watchdog, and a shared
//                response bus with per-requester valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_arbiter
   import fpu_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64,
   parameter int ID_W    = $clog2(N_REQ)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req_valid,
   output logic [N_REQ-1:0]    req_ready,
   input  logic [N_REQ*32-1:0] req_op_a,
   input  logic [N_REQ*32-1:0] req_op_b,
   output logic [N_REQ-1:0]    resp_valid,
   input  logic [N_REQ-1:0]    resp_ready,
   output logic [31:0]         resp_data,
   output logic [3:0]          resp_status,
   output logic [ID_W-1:0]     resp_id,
   output logic                fpu_start,
   output logic [31:0]         fpu_op_a,
   output logic [31:0]         fpu_op_b,
   input  logic                fpu_done,
   input  logic [31:0]         fpu_result,
   input  logic [3:0]          fpu_status,
   output logic                busy
);

   // Timer counts 0..TIMEOUT-1 while waiting on the core
   localparam int              TMR_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
   localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(N_REQ - 1);

   state_t            state_q, state_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [31:0]       op_a_q, op_a_d;
   logic [31:0]       op_b_q, op_b_d;
   logic [31:0]       data_q, data_d;
   logic [3:0]        status_q, status_d;

   logic [N_REQ-1:0]  w_grant;
   logic [ID_W-1:0]   w_grant_idx;
   logic              w_any_req;
   logic [N_REQ-1:0]  w_id_oh;
   logic [31:0]       w_sel_a;
   logic [31:0]       w_sel_b;
   logic              w_idle;
   logic              w_accept;
   logic              w_resp_ack;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr (
      .req_i        (req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (w_grant),
      .grant_idx_o  (w_grant_idx),
      .any_req_o    (w_any_req)
   );

   // Operand mux for the currently granted requester
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_a = req_op_a[32*i +: 32];
            w_sel_b = req_op_b[32*i +: 32];
         end
      end
   end

   // One-hot decode of the requester currently being served
   always_comb begin
      w_id_oh = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (id_q == ID_W'(i)) begin
            w_id_oh[i] = 1'b1;
         end
      end
   end

   // Ready is held off while reset is asserted so no handshake can slip in
   assign w_idle     = (state_q == IDLE);
   assign w_accept   = w_idle && reset && w_any_req;
   assign w_resp_ack = |(w_id_oh & resp_ready);

   // Next-state and datapath update
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      timer_d      = timer_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      data_d       = data_q;
      status_d     = status_q;
      case (state_q)
         IDLE: begin
            if (w_accept) begin
               op_a_d  = w_sel_a;
               op_b_d  = w_sel_b;
               id_d    = w_grant_idx;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // A done pulse here belongs to nobody and is dropped
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (fpu_done) begin
               data_d   = fpu_result;
               status_d = core_status(fpu_status);
               state_d  = RESP;
            end else if (timer_q == TMR_LAST) begin
               data_d   = '0;
               status_d = TIMEOUT_STATUS;
               state_d  = RESP;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         RESP: begin
            if (w_resp_ack) begin
               last_grant_d = id_q;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= LAST_INIT;
         id_q         <= '0;
         timer_q      <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         data_q       <= '0;
         status_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         timer_q      <= timer_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         data_q       <= data_d;
         status_q     <= status_d;
      end
   end

   assign req_ready   = w_accept ? w_grant : '0;
   assign fpu_start   = (state_q == ISSUE);
   assign fpu_op_a    = op_a_q;
   assign fpu_op_b    = op_b_q;
   assign resp_valid  = (state_q == RESP) ? w_id_oh : '0;
   assign resp_data   = data_q;
   assign resp_status = status_q;
   assign resp_id     = id_q;
   assign busy        = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_arbiter
//  Description : Self-checking bench for fpu_arbiter. Directed scenarios
//                followed by randomized traffic, all judged by a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_arbiter;

   localparam int N   = 4;
   localparam int TMO = 64;
   localparam int IDW = 2;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
   logic [N*32-1:0] req_op_a, req_op_b;
   logic [31:0]    resp_data, fpu_op_a, fpu_op_b, fpu_result;
   logic [3:0]     resp_status, fpu_status;
   logic [IDW-1:0] resp_id;
   logic           fpu_start, fpu_done, busy;

   fpu_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op_a    (req_op_a),
      .req_op_b    (req_op_b),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_data   (resp_data),
      .resp_status (resp_status),
      .resp_id     (resp_id),
      .fpu_start   (fpu_start),
      .fpu_op_a    (fpu_op_a),
      .fpu_op_b    (fpu_op_b),
      .fpu_done    (fpu_done),
      .fpu_result  (fpu_result),
      .fpu_status  (fpu_status),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Stimulus controls
   logic [N-1:0] t_req;
   logic [31:0]  t_a [N];
   logic [31:0]  t_b [N];
   int           t_lat;      // core latency after start; <0 never, 0 lands in issue cycle
   logic [31:0]  t_res;
   logic [3:0]   t_st;
   int           t_hold;     // cycles the served requester withholds resp_ready
   logic         t_stray;
   logic         drop_on_accept;

   // Transaction-level reference model
   bit          active;
   int          last;
   int          cyc;
   int          m_id, acc_cyc, done_cyc, resp_cyc, m_hold;
   logic [31:0] m_a, m_b, m_res, m_data;
   logic [3:0]  m_res_st, m_status;

   // Observations of the DUT
   int          obs_grants[$];
   int          obs_starts[$];
   int          obs_acc, obs_resp, obs_resp_cnt;
   logic [3:0]  obs_status;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int from);
      for (int k = 1; k <= N; k++) begin
         if (v[(from + k) % N]) return (from + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] r;
      r = '0;
      if (i >= 0) r[i] = 1'b1;
      return r;
   endfunction

   function automatic int idx_of(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int qat(input int q[$], input int k);
      if (k < q.size()) return q[k];
      return -999;
   endfunction

   task automatic clear_obs();
      obs_grants.delete();
      obs_starts.delete();
      obs_acc      = -1;
      obs_resp     = -1;
      obs_resp_cnt = 0;
      obs_status   = '0;
   endtask

   // One clock cycle: drive, check against model, advance model
   task automatic run_cycle();
      int   g;
      logic resp_now;
      req_valid = t_req;
      for (int i = 0; i < N; i++) begin
         req_op_a[32*i +: 32] = t_a[i];
         req_op_b[32*i +: 32] = t_b[i];
      end
      resp_now   = active && (cyc >= resp_cyc);
      resp_ready = N'($urandom);
      if (active) resp_ready[m_id] = resp_now && (cyc >= resp_cyc + m_hold);
      fpu_done   = t_stray || (active && cyc == done_cyc);
      fpu_result = active ? m_res : $urandom;
      fpu_status = active ? m_res_st : 4'($urandom);
      #1;
      g = active ? -1 : rr_pick(t_req, last);
      chk("req_ready", req_ready, oh(g));
      chk("busy", busy, active);
      chk("fpu_start", fpu_start, active && cyc == acc_cyc + 1);
      chk("resp_valid", resp_valid, resp_now ? oh(m_id) : '0);
      if (resp_now) begin
         chk("resp_data", resp_data, m_data);
         chk("resp_status", resp_status, m_status);
         chk("resp_id", resp_id, m_id);
      end
      if (active && cyc > acc_cyc && cyc < resp_cyc) begin
         chk("fpu_op_a", fpu_op_a, m_a);
         chk("fpu_op_b", fpu_op_b, m_b);
      end
      if (req_ready != '0) begin
         obs_grants.push_back(idx_of(req_ready));
         if (obs_acc < 0) obs_acc = cyc;
      end
      if (fpu_start) obs_starts.push_back(cyc);
      if (resp_valid != '0) begin
         obs_resp_cnt++;
         if (obs_resp < 0) begin
            obs_resp   = cyc;
            obs_status = resp_status;
         end
      end
      if (active && resp_ready[m_id]) begin
         active = 1'b0;
         last   = m_id;
      end else if (g >= 0) begin
         active   = 1'b1;
         m_id     = g;
         acc_cyc  = cyc;
         m_a      = t_a[g];
         m_b      = t_b[g];
         m_res    = t_res;
         m_res_st = t_st;
         m_hold   = t_hold;
         if (t_lat >= 1 && t_lat <= TMO) begin
            done_cyc = cyc + 1 + t_lat;
            resp_cyc = done_cyc + 1;
            m_data   = t_res;
            m_status = {1'b0, t_st[2:0]};
         end else begin
            done_cyc = (t_lat < 0) ? -10 : cyc + 1 + t_lat;
            resp_cyc = cyc + 1 + TMO + 1;
            m_data   = 32'h0;
            m_status = 4'b1000;
         end
         if (drop_on_accept) t_req[g] = 1'b0;
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " req_ready"}, req_ready, 0);
      chk({tag, " resp_valid"}, resp_valid, 0);
      chk({tag, " resp_data"}, resp_data, 0);
      chk({tag, " resp_status"}, resp_status, 0);
      chk({tag, " resp_id"}, resp_id, 0);
      chk({tag, " fpu_start"}, fpu_start, 0);
      chk({tag, " fpu_op_a"}, fpu_op_a, 0);
      chk({tag, " fpu_op_b"}, fpu_op_b, 0);
      chk({tag, " busy"}, busy, 0);
   endtask

   task automatic apply_reset(input int ncyc);
      reset    = 1'b0;
      fpu_done = 1'b0;
      #1;
      chk_zero("reset_entry");
      repeat (ncyc) @(posedge clock);
      #1;
      chk_zero("reset_held");
      active = 1'b0;
      last   = N - 1;
      reset  = 1'b1;
   endtask

   // Run until one transaction has been accepted and consumed
   task automatic run_txn(input string tag);
      bit seen;
      int n;
      seen = 1'b0;
      for (n = 0; n < 300; n++) begin
         run_cycle();
         if (active) seen = 1'b1;
         else if (seen) break;
      end
      chk({tag, " completes"}, n < 300, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      req_valid = '0; req_op_a = '0; req_op_b = '0; resp_ready = '0;
      fpu_done = 1'b0; fpu_result = '0; fpu_status = '0;
      t_req = '0; t_lat = 1; t_res = '0; t_st = '0; t_hold = 0;
      t_stray = 1'b0; drop_on_accept = 1'b1;
      for (int i = 0; i < N; i++) begin t_a[i] = '0; t_b[i] = '0; end
      active = 1'b0; last = N - 1; cyc = 0;
      m_id = 0; acc_cyc = 0; done_cyc = -10; resp_cyc = 0; m_hold = 0;
      m_a = '0; m_b = '0; m_res = '0; m_data = '0; m_res_st = '0; m_status = '0;
      clear_obs();
      repeat (2) @(posedge clock);
      #1;
      apply_reset(2);

      // Single request: 1.0 + 1.0 with a 3-cycle core
      clear_obs();
      t_a[0] = 32'h3E000000; t_b[0] = 32'h3E000000;
      t_lat = 3; t_res = 32'h40000000; t_st = 4'h0; t_hold = 0;
      t_req = 4'b0001;
      run_txn("single");
      chk("single grant", qat(obs_grants, 0), 0);
      chk("single accept_to_start", qat(obs_starts, 0) - obs_acc, 1);
      chk("single start_to_resp", obs_resp - qat(obs_starts, 0), 4);

      // Contention from reset: all four held valid
      apply_reset(1);
      clear_obs();
      drop_on_accept = 1'b0;
      for (int i = 0; i < N; i++) begin t_a[i] = $urandom; t_b[i] = $urandom; end
      t_lat = 1; t_res = $urandom; t_st = 4'h2; t_req = 4'b1111;
      repeat (5) run_txn("contend");
      t_req = '0;
      drop_on_accept = 1'b1;
      chk("contend grant0", qat(obs_grants, 0), 0);
      chk("contend grant1", qat(obs_grants, 1), 1);
      chk("contend grant2", qat(obs_grants, 2), 2);
      chk("contend grant3", qat(obs_grants, 3), 3);
      chk("contend grant4", qat(obs_grants, 4), 0);
      for (int k = 1; k < 5; k++)
         chk("contend start_gap", (qat(obs_starts, k) - qat(obs_starts, k - 1)) >= 4, 1);

      // Watchdog expiry, then a stray done while idle
      clear_obs();
      t_lat = -1; t_res = 32'hDEADBEEF; t_st = 4'h7; t_req = 4'b0010;
      run_txn("timeout");
      chk("timeout start_to_resp", obs_resp - qat(obs_starts, 0), TMO + 1);
      chk("timeout status", obs_status, 4'b1000);
      t_stray = 1'b1;
      run_cycle();
      t_stray = 1'b0;
      repeat (3) run_cycle();

      // Done in the last watchdog cycle wins, bit3 of core status masked
      clear_obs();
      t_lat = TMO; t_res = 32'h12345678; t_st = 4'b1011; t_req = 4'b0001;
      run_txn("done_last");
      chk("done_last start_to_resp", obs_resp - qat(obs_starts, 0), TMO + 1);
      chk("done_last status", obs_status, 4'b0011);

      // Back-pressure: response held 10 cycles, another requester waiting
      clear_obs();
      t_lat = 2; t_res = 32'hCAFEF00D; t_st = 4'h1; t_hold = 10; t_req = 4'b0101;
      run_txn("backpressure");
      t_req = '0; t_hold = 0;
      chk("bp grant", qat(obs_grants, 0), 2);
      chk("bp resp_cycles", obs_resp_cnt, 11);
      chk("bp start_count", obs_starts.size(), 1);

      // Reset in the middle of a wait, then a late done and a fresh request
      t_lat = -1; t_req = 4'b0001;
      repeat (4) run_cycle();
      chk("midwait busy_before_reset", busy, 1);
      apply_reset(2);
      t_req = '0;
      clear_obs();
      t_stray = 1'b1;
      run_cycle();
      t_stray = 1'b0;
      run_cycle();
      chk("aborted no_resp", obs_resp_cnt, 0);
      clear_obs();
      t_lat = 2; t_res = 32'h0BADF00D; t_st = 4'h4; t_req = 4'b0100;
      run_txn("after_reset");
      chk("after_reset first_grant", qat(obs_grants, 0), 2);

      // Randomized traffic
      drop_on_accept = 1'b0;
      for (int n = 0; n < 2500; n++) begin
         int r;
         t_req = N'($urandom);
         for (int i = 0; i < N; i++) begin t_a[i] = $urandom; t_b[i] = $urandom; end
         r = $urandom_range(0, 19);
         if (r == 0)      t_lat = -1;
         else if (r == 1) t_lat = 0;
         else if (r == 2) t_lat = TMO;
         else if (r == 3) t_lat = TMO + 1;
         else             t_lat = $urandom_range(1, 6);
         t_res  = $urandom;
         t_st   = 4'($urandom);
         t_hold = $urandom_range(0, 3);
         run_cycle();
      end
      t_req = '0;
      for (int n = 0; n < 200 && active; n++) run_cycle();
      chk("drain idle", active, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
